// File: rtl/comparator_seq_if.sv
// Request/response bundle for the chunked magnitude comparator.
// Latency: none, wires only.
// Backpressure: the request side uses in_valid/in_ready and the response side uses out_valid/out_ready.
interface comparator_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic             out_gt;
    logic             out_lt;
    logic             out_eq;

    // The requester drives operands and the result-accept signal.
    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, out_gt, out_lt, out_eq
    );

    // The comparator receives operands and produces flags.
    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, out_gt, out_lt, out_eq
    );
endinterface

// File: rtl/comparator_seq.sv
// Multi-cycle magnitude comparator that scans CHUNK bits per cycle from the MSB, in signed or unsigned mode.
// Latency: result is valid NCHUNK+1 edges after accept, counting the accept edge as the first; COMPARATOR_EARLY_EXIT_EN stops at the first differing chunk.
// Backpressure: one request in flight; in_ready is high only in IDLE, and the result holds in DONE until out_ready.
module comparator_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    comparator_seq_if.slave   bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             acc_gt, acc_gt_d;
    logic             acc_lt, acc_lt_d;
    logic             acc_eq, acc_eq_d;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;

    assign chunk_a = a_q[idx*CHUNK +: CHUNK];
    assign chunk_b = b_q[idx*CHUNK +: CHUNK];

    // Register the FSM state, scan index, captured operands and accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= IDX_MAX;
            a_q    <= '0;
            b_q    <= '0;
            acc_gt <= 1'b0;
            acc_lt <= 1'b0;
            acc_eq <= 1'b0;
        end else begin
            state  <= state_d;
            idx    <= idx_d;
            a_q    <= a_d;
            b_q    <= b_d;
            acc_gt <= acc_gt_d;
            acc_lt <= acc_lt_d;
            acc_eq <= acc_eq_d;
        end
    end

    // Compute the next state: capture on accept, fold in one chunk per RUN cycle, release on out_ready.
    always_comb begin
        state_d  = state;
        idx_d    = idx;
        a_d      = a_q;
        b_d      = b_q;
        acc_gt_d = acc_gt;
        acc_lt_d = acc_lt;
        acc_eq_d = acc_eq;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    // Flipping the sign bit of both operands maps two's complement onto unsigned order.
                    a_d      = {bus.a[WIDTH-1] ^ bus.is_signed, bus.a[WIDTH-2:0]};
                    b_d      = {bus.b[WIDTH-1] ^ bus.is_signed, bus.b[WIDTH-2:0]};
                    acc_gt_d = 1'b0;
                    acc_lt_d = 1'b0;
                    acc_eq_d = 1'b1;
                    idx_d    = IDX_MAX;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Only the first differing chunk can decide; later chunks are ignored.
                if (acc_eq) begin
                    if (chunk_a > chunk_b) begin
                        acc_gt_d = 1'b1;
                        acc_eq_d = 1'b0;
                    end else if (chunk_a < chunk_b) begin
                        acc_lt_d = 1'b1;
                        acc_eq_d = 1'b0;
                    end
                end
                if (idx == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx - 1'b1;
                end
`ifdef COMPARATOR_EARLY_EXIT_EN
                if (acc_eq && (chunk_a != chunk_b)) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (bus.out_ready) begin
                    acc_gt_d = 1'b0;
                    acc_lt_d = 1'b0;
                    acc_eq_d = 1'b0;
                    idx_d    = IDX_MAX;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = IDX_MAX;
            end
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    // Gate the flags so that they read as zero outside DONE, even while the accumulators are still working.
    assign bus.out_gt    = (state == DONE) & acc_gt;
    assign bus.out_lt    = (state == DONE) & acc_lt;
    assign bus.out_eq    = (state == DONE) & acc_eq;

endmodule
